// File: rtl/vga_pkg.sv
// ----------------------------------------------------------------------------
// vga_pkg
// Shared types and constants for the VGA frame-buffer arbiter.
//   state_e     : arbiter FSM states (IDLE / READ / WRITE)
//   H_PIX_DEF   : default pixels per line
//   V_PIX_DEF   : default lines per frame
//   FB_DEPTH    : default frame-buffer depth in pixels
//   PIX_W       : RGB888 pixel width
//   ADDR_W      : linear pixel address width
//   Y_W / X_W   : line index / pixel index widths
//   line_base() : first linear address of a line
// ----------------------------------------------------------------------------
package vga_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

    localparam int H_PIX_DEF = 640;
    localparam int V_PIX_DEF = 480;
    localparam int FB_DEPTH  = H_PIX_DEF * V_PIX_DEF;
    localparam int PIX_W     = 24;
    localparam int ADDR_W    = 19;
    localparam int Y_W       = 10;
    localparam int X_W       = 10;

    // The frame never exceeds 2^19 pixels, so a 19-bit product cannot wrap.
    function automatic logic [ADDR_W-1:0] line_base(input logic [Y_W-1:0] y,
                                                    input int unsigned    h);
        return ADDR_W'(y) * ADDR_W'(h);
    endfunction

endpackage

// File: rtl/vga_fb_addr_gen.sv
// ----------------------------------------------------------------------------
// vga_fb_addr_gen
// Read-burst address generator: latches the line base (y * H_PIX) at burst
// start, then steps the x counter once per read issue.
// Ports:
//   clk      : clock, rising edge
//   rst_ni   : asynchronous active-low reset
//   start_i  : load base for line y_i, clear x
//   y_i      : line index sampled with start_i
//   adv_i    : advance x by one
//   addr_o   : current linear read address (base + x)
//   x_o      : current x index
//   last_o   : x is the final pixel of the line
// ----------------------------------------------------------------------------
module vga_fb_addr_gen
    import vga_pkg::*;
#(
    parameter int H_PIX = H_PIX_DEF
) (
    input  logic              clk,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [Y_W-1:0]    y_i,
    input  logic              adv_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [X_W-1:0]    x_o,
    output logic              last_o
);

    logic [ADDR_W-1:0] base_q, base_d;
    logic [X_W-1:0]    x_q,    x_d;

    always_comb begin
        base_d = base_q;
        x_d    = x_q;
        if (start_i) begin
            base_d = line_base(y_i, H_PIX);
            x_d    = '0;
        end else if (adv_i) begin
            x_d = x_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            base_q <= '0;
            x_q    <= '0;
        end else begin
            base_q <= base_d;
            x_q    <= x_d;
        end
    end

    assign addr_o = base_q + ADDR_W'(x_q);
    assign x_o    = x_q;
    assign last_o = (x_q == X_W'(H_PIX - 1));

endmodule

// File: rtl/vga_fb_arbiter.sv
// ----------------------------------------------------------------------------
// vga_fb_arbiter
// Arbitrates a single frame-buffer port between line prefetch bursts (display
// side) and single-pixel writes (render side). Reads win over writes.
//
// Configuration macro: FB_WR_INTERLEAVE_EN
//   undefined : writes are served only from IDLE; a burst is H_PIX
//               back-to-back read issues.
//   defined   : a pending write steals one cycle of a burst after every
//               WR_GAP consecutive read issues.
//
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   line_req   : one-cycle request to prefetch line line_y
//   line_y     : line index sampled with line_req
//   line_busy  : a line read is pending or in progress
//   rd_valid   : rd_data / rd_idx valid
//   rd_data    : pixel read from the frame buffer
//   rd_idx     : x index of rd_data
//   wr_req     : write request level, held until wr_ack
//   wr_addr    : linear pixel address of the write
//   wr_data    : pixel to write
//   wr_ack     : one-cycle write acceptance
//   mem_en     : frame-buffer port enable
//   mem_we     : frame-buffer write strobe
//   mem_addr   : frame-buffer address
//   mem_wdata  : frame-buffer write data
//   mem_rdata  : frame-buffer read data, one cycle after a read issue
//   err        : sticky error (bad line, dropped request, bad write address)
// ----------------------------------------------------------------------------
module vga_fb_arbiter
    import vga_pkg::*;
#(
    parameter int H_PIX  = H_PIX_DEF,
    parameter int V_PIX  = V_PIX_DEF,
    parameter int WR_GAP = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              line_req,
    input  logic [Y_W-1:0]    line_y,
    output logic              line_busy,
    output logic              rd_valid,
    output logic [PIX_W-1:0]  rd_data,
    output logic [X_W-1:0]    rd_idx,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [PIX_W-1:0]  wr_data,
    output logic              wr_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [PIX_W-1:0]  mem_wdata,
    input  logic [PIX_W-1:0]  mem_rdata,
    output logic              err
);

    // One extra bit on the limits so V_PIX = 2^Y_W and a full 2^19 frame
    // still compare correctly.
    localparam int YL_W = Y_W + 1;
    localparam int AL_W = ADDR_W + 1;
    localparam logic [YL_W-1:0] V_LIM  = YL_W'(V_PIX);
    localparam logic [AL_W-1:0] FB_LIM = AL_W'(H_PIX * V_PIX);

    state_e            state_q, state_d;
    logic              pending_q, pending_d;
    logic [Y_W-1:0]    pend_y_q, pend_y_d;
    logic              err_q, err_d;
    logic              rd_valid_q, rd_valid_d;
    logic [X_W-1:0]    rd_idx_q, rd_idx_d;

    logic              line_in_range;
    logic              line_ok;
    logic              wr_addr_ok;
    logic              start;
    logic              stall;
    logic              issue;
    logic              write_slot;
    logic              write_go;

    logic [ADDR_W-1:0] rd_addr;
    logic [X_W-1:0]    rd_x;
    logic              rd_last;

    assign line_in_range = ({1'b0, line_y} < V_LIM);
    assign line_ok       = line_req && line_in_range;
    assign wr_addr_ok    = ({1'b0, wr_addr} < FB_LIM);

    // Burst starts on the IDLE->READ transition; the pending slot is freed
    // at the same edge so the next line can queue behind this burst.
    assign start      = (state_q == ST_IDLE) && pending_q;
    assign issue      = (state_q == ST_READ) && !stall;
    assign write_slot = (state_q == ST_WRITE) || stall;
    assign write_go   = write_slot && wr_addr_ok;

    vga_fb_addr_gen #(
        .H_PIX (H_PIX)
    ) u_addr_gen (
        .clk     (clk),
        .rst_ni  (rst),
        .start_i (start),
        .y_i     (pend_y_q),
        .adv_i   (issue && !rd_last),
        .addr_o  (rd_addr),
        .x_o     (rd_x),
        .last_o  (rd_last)
    );

`ifdef FB_WR_INTERLEAVE_EN
    localparam int RUN_W = $clog2(WR_GAP + 1);
    localparam logic [RUN_W-1:0] GAP = RUN_W'(WR_GAP);

    // Consecutive read issues since burst start or the last stolen slot.
    // Saturates so a write that turns up late is served on the next cycle.
    logic [RUN_W-1:0] run_q, run_d;

    assign stall = (state_q == ST_READ) && wr_req && (run_q >= GAP);

    always_comb begin
        run_d = run_q;
        if (start || stall) begin
            run_d = '0;
        end else if (issue && (run_q < GAP)) begin
            run_d = run_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q <= '0;
        end else begin
            run_q <= run_d;
        end
    end
`else
    // No write slots inside a burst. A negative gap is meaningless, so this
    // is constant 0 for every legal WR_GAP.
    assign stall = (WR_GAP < 0);
`endif

    // Next-state and bookkeeping
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        pend_y_d   = pend_y_q;
        err_d      = err_q;
        rd_valid_d = issue;
        rd_idx_d   = issue ? rd_x : rd_idx_q;

        case (state_q)
            ST_IDLE: begin
                // A request arriving this cycle still beats a waiting write:
                // hold off the write so the read goes first next cycle.
                if (pending_q) begin
                    state_d = ST_READ;
                end else if (wr_req && !line_ok) begin
                    state_d = ST_WRITE;
                end
            end
            ST_READ: begin
                if (issue && rd_last) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (start) begin
            pending_d = 1'b0;
        end
        if (line_ok && !pending_q) begin
            pending_d = 1'b1;
            pend_y_d  = line_y;
        end

        if (line_req && !line_in_range) err_d = 1'b1;
        if (line_ok && pending_q)        err_d = 1'b1;
        if (write_slot && !wr_addr_ok)   err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            pending_q  <= 1'b0;
            pend_y_q   <= '0;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_idx_q   <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            pend_y_q   <= pend_y_d;
            err_q      <= err_d;
            rd_valid_q <= rd_valid_d;
            rd_idx_q   <= rd_idx_d;
        end
    end

    // Outputs are decoded from registered state so reset drives them all
    // low immediately. rd_data is gated so it is 0 whenever not valid.
    assign line_busy = pending_q || (state_q == ST_READ);
    assign rd_valid  = rd_valid_q;
    assign rd_idx    = rd_idx_q;
    assign rd_data   = rd_valid_q ? mem_rdata : '0;
    assign wr_ack    = write_slot;
    assign mem_en    = issue || write_go;
    assign mem_we    = write_go;
    assign mem_addr  = issue ? rd_addr : (write_go ? wr_addr : '0);
    assign mem_wdata = write_go ? wr_data : '0;
    assign err       = err_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
module tb_vga_fb_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        line_req = 1'b0;
    logic [9:0]  line_y = '0;
    logic        line_busy;
    logic        rd_valid;
    logic [23:0] rd_data;
    logic [9:0]  rd_idx;
    logic        wr_req = 1'b0;
    logic [18:0] wr_addr = '0;
    logic [23:0] wr_data = '0;
    logic        wr_ack;
    logic        mem_en;
    logic        mem_we;
    logic [18:0] mem_addr;
    logic [23:0] mem_wdata;
    logic [23:0] mem_rdata = '0;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    vga_fb_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .line_req  (line_req),
        .line_y    (line_y),
        .line_busy (line_busy),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_idx    (rd_idx),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ack    (wr_ack),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .err       (err)
    );

    // Frame-buffer model: data is a fixed function of the address, one cycle late.
    function automatic logic [23:0] pat(input logic [18:0] a);
        return {5'h15, a} ^ 24'h3CA55A;
    endfunction

    always @(posedge clk) begin
        if (mem_en && !mem_we) mem_rdata <= pat(mem_addr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_flags"}, 32'({line_busy, rd_valid, wr_ack, mem_en, mem_we, err}), 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        chk({tag, "_rd_data"}, 32'(rd_data), 32'd0);
        chk({tag, "_rd_idx"}, 32'(rd_idx), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        #1;
        check_all_zero(tag);
        cyc();
        rst = 1'b1;
    endtask

    typedef struct {
        logic [18:0] addr;
        logic [23:0] data;
        logic        exp_en;
        logic        exp_err;
    } wvec_t;

    wvec_t wv[6];

    int bad_addr, bad_rv, n_iss, ack_at, we_early, lat, last_c, first_c, n;
    int last_iss_c, we_cnt, ack_c;
    logic        we_at_ack;
    logic [18:0] addr_at_ack;

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        wv[0] = '{19'd0,      24'hFF0000, 1'b1, 1'b0};
        wv[1] = '{19'd1,      24'h00FF00, 1'b1, 1'b0};
        wv[2] = '{19'd12345,  24'h0000FF, 1'b1, 1'b0};
        wv[3] = '{19'd307199, 24'hABCDEF, 1'b1, 1'b0};
        wv[4] = '{19'd307200, 24'h111111, 1'b0, 1'b1};
        wv[5] = '{19'd524287, 24'h222222, 1'b0, 1'b1};

        // ---- reset state ----
        #2;
        check_all_zero("reset");
        cyc();
        rst = 1'b1;

        // ---- read line 2 ----
        line_req = 1'b1; line_y = 10'd2;
        cyc();
        line_req = 1'b0;
        chk("rl_busy_pending", 32'(line_busy), 32'd1);
        chk("rl_idle_no_en", 32'(mem_en), 32'd0);
        cyc();
        bad_addr = 0; bad_rv = 0;
        for (int i = 0; i < 640; i++) begin
            if (!(mem_en && !mem_we && mem_addr == 19'(1280 + i) && line_busy)) bad_addr++;
            if (i == 0) begin
                if (rd_valid) bad_rv++;
            end else if (!(rd_valid && rd_idx == 10'(i - 1) && rd_data == pat(19'(1280 + i - 1)))) begin
                bad_rv++;
            end
            cyc();
        end
        chk("rl_issue_seq", 32'(bad_addr), 32'd0);
        chk("rl_rdvalid_seq", 32'(bad_rv), 32'd0);
        chk("rl_end_no_en", 32'(mem_en), 32'd0);
        chk("rl_end_busy", 32'(line_busy), 32'd0);
        chk("rl_last_valid", 32'(rd_valid), 32'd1);
        chk("rl_last_idx", 32'(rd_idx), 32'd639);
        chk("rl_last_data", 32'(rd_data), 32'(pat(19'd1919)));
        cyc();
        chk("rl_tail_valid", 32'(rd_valid), 32'd0);

        // ---- write / read collision ----
        line_req = 1'b1; line_y = 10'd0;
        wr_req = 1'b1; wr_addr = 19'd5; wr_data = 24'h123456;
        cyc();
        line_req = 1'b0;
        n_iss = 0; ack_at = -1; we_early = 0;
        for (int c = 1; c <= 800 && ack_at < 0; c++) begin
            if (wr_ack) begin
                ack_at = c;
                chk("col_ack_we", 32'(mem_we), 32'd1);
                chk("col_ack_addr", 32'(mem_addr), 32'd5);
                chk("col_ack_wdata", 32'(mem_wdata), 32'h123456);
            end else begin
                if (mem_en && !mem_we) n_iss++;
                if (mem_we) we_early++;
                cyc();
            end
        end
        wr_req = 1'b0;
`ifdef FB_WR_INTERLEAVE_EN
        chk("col_ack_cycle", 32'(ack_at), 32'd10);
        chk("col_reads_before_ack", 32'(n_iss), 32'd8);
`else
        chk("col_ack_cycle", 32'(ack_at), 32'd643);
        chk("col_reads_before_ack", 32'(n_iss), 32'd640);
`endif
        chk("col_no_early_write", 32'(we_early), 32'd0);
        cyc();
        for (int c = 0; c < 800 && line_busy; c++) cyc();
        chk("col_drained", 32'(line_busy), 32'd0);
        chk("col_err", 32'(err), 32'd0);
        cyc();

        // ---- write table ----
        for (int k = 0; k < 6; k++) begin
            wr_req = 1'b1; wr_addr = wv[k].addr; wr_data = wv[k].data;
            lat = 0;
            while (!wr_ack && lat < 5) begin
                cyc();
                lat++;
            end
            chk($sformatf("wr%0d_latency", k), 32'(lat), 32'd1);
            chk($sformatf("wr%0d_en", k), 32'(mem_en), 32'(wv[k].exp_en));
            chk($sformatf("wr%0d_we", k), 32'(mem_we), 32'(wv[k].exp_en));
            chk($sformatf("wr%0d_addr", k), 32'(mem_addr), wv[k].exp_en ? 32'(wv[k].addr) : 32'd0);
            chk($sformatf("wr%0d_wdata", k), 32'(mem_wdata), wv[k].exp_en ? 32'(wv[k].data) : 32'd0);
            wr_req = 1'b0;
            cyc();
            chk($sformatf("wr%0d_ack_pulse", k), 32'(wr_ack), 32'd0);
            chk($sformatf("wr%0d_err", k), 32'(err), 32'(wv[k].exp_err));
        end

        // ---- out-of-range line ----
        do_reset("rst_a");
        line_req = 1'b1; line_y = 10'd480;
        cyc();
        line_req = 1'b0;
        chk("bad_line_err", 32'(err), 32'd1);
        chk("bad_line_busy", 32'(line_busy), 32'd0);
        n = 0;
        for (int c = 0; c < 6; c++) begin
            if (mem_en) n++;
            cyc();
        end
        chk("bad_line_no_en", 32'(n), 32'd0);

        // ---- queueing ----
        do_reset("rst_b");
        line_req = 1'b1; line_y = 10'd3;
        cyc();
        line_req = 1'b0;
        cyc();
        chk("q_first_addr", 32'(mem_addr), 32'd1920);
        chk("q_err_clear", 32'(err), 32'd0);
        repeat (100) cyc();
        line_req = 1'b1; line_y = 10'd4;
        cyc();
        line_y = 10'd5;
        cyc();
        line_req = 1'b0;
        chk("q_third_err", 32'(err), 32'd1);
        chk("q_busy", 32'(line_busy), 32'd1);
        last_c = -1; first_c = -1;
        for (int c = 0; c < 1500 && first_c < 0; c++) begin
            if (mem_en && mem_addr == 19'd2559) last_c = c;
            if (mem_en && mem_addr == 19'd2560) first_c = c;
            cyc();
        end
        chk("q_second_start_found", 32'(first_c >= 0), 32'd1);
        chk("q_gap", 32'(first_c - last_c), 32'd2);
        n = 0;
        for (int c = 0; c < 800 && line_busy; c++) begin
            if (mem_en) n++;
            cyc();
        end
        chk("q_second_len", 32'(n), 32'd639);
        n = 0;
        for (int c = 0; c < 4; c++) begin
            if (mem_en || line_busy) n++;
            cyc();
        end
        chk("q_no_third_burst", 32'(n), 32'd0);

        // ---- reset in the middle of a burst ----
        do_reset("rst_c");
        line_req = 1'b1; line_y = 10'd1;
        cyc();
        line_req = 1'b0;
        cyc();
        repeat (99) cyc();
        chk("rb_cycle100_addr", 32'(mem_addr), 32'd739);
        rst = 1'b0;
        #1;
        check_all_zero("rb_async");
        cyc();
        chk("rb_held_valid", 32'(rd_valid), 32'd0);
        rst = 1'b1;
        line_req = 1'b1; line_y = 10'd7;
        cyc();
        line_req = 1'b0;
        chk("rb_accept_busy", 32'(line_busy), 32'd1);
        chk("rb_no_stale_valid", 32'(rd_valid), 32'd0);
        cyc();
        chk("rb_fresh_addr", 32'(mem_addr), 32'd4480);
        chk("rb_fresh_no_valid", 32'(rd_valid), 32'd0);
        cyc();
        chk("rb_fresh_valid", 32'(rd_valid), 32'd1);
        chk("rb_fresh_idx", 32'(rd_idx), 32'd0);
        chk("rb_fresh_data", 32'(rd_data), 32'(pat(19'd4480)));
        for (int c = 0; c < 800 && line_busy; c++) cyc();
        cyc();

        // ---- write held during a burst ----
        line_req = 1'b1; line_y = 10'd10;
        cyc();
        line_req = 1'b0;
        cyc();
        wr_req = 1'b1; wr_addr = 19'd77; wr_data = 24'h0F0F0F;
        n_iss = 0; last_iss_c = -1; we_cnt = 0; ack_c = -1;
        we_at_ack = 1'b0; addr_at_ack = '0;
        for (int c = 1; c <= 660; c++) begin
            if (mem_en && !mem_we) begin
                n_iss++;
                last_iss_c = c;
            end
            if (mem_we) we_cnt++;
            if (wr_ack) begin
                if (ack_c < 0) ack_c = c;
                we_at_ack = mem_we;
                addr_at_ack = mem_addr;
                wr_req = 1'b0;
            end
            cyc();
        end
        chk("wb_reads", 32'(n_iss), 32'd640);
        chk("wb_writes", 32'(we_cnt), 32'd1);
        chk("wb_ack_we", 32'(we_at_ack), 32'd1);
        chk("wb_ack_addr", 32'(addr_at_ack), 32'd77);
`ifdef FB_WR_INTERLEAVE_EN
        chk("wb_ack_cycle", 32'(ack_c), 32'd9);
        chk("wb_burst_len", 32'(last_iss_c), 32'd641);
`else
        chk("wb_ack_cycle", 32'(ack_c), 32'd642);
        chk("wb_burst_len", 32'(last_iss_c), 32'd640);
`endif
        chk("wb_err", 32'(err), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_fb_arbiter.md
VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 Parameter H_PIX, default 640, pixels per line.
REQ-002 Parameter V_PIX, default 480, lines per frame.
REQ-003 Parameter WR_GAP, default 8, read-burst cycles between interleaved write slots (see REQ-031).
REQ-004 Port list SHALL be, in order:
- clk  in  1  pixel-domain clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- line_req  in  1  one-cycle pulse: prefetch line line_y.
- line_y  in  10  line index, sampled with line_req.
- line_busy  out  1  high while a line read is pending or in progress.
- rd_valid  out  1  rd_data/rd_idx valid this cycle.
- rd_data  out  24  RGB888 pixel read from the frame buffer.
- rd_idx  out  10  x index of rd_data.
- wr_req  in  1  level; held high until wr_ack.
- wr_addr  in  19  linear pixel address (y*H_PIX+x).
- wr_data  in  24  RGB888 pixel to write.
- wr_ack  out  1  one-cycle pulse: write accepted.
- mem_en  out  1  frame-buffer port enable.
- mem_we  out  1  write strobe, qualified by mem_en.
- mem_addr  out  19  frame-buffer address.
- mem_wdata  out  24  write data.
- mem_rdata  in  24  read data, valid exactly 1 cycle after a read issue.
- err  out  1  sticky error flag.

Function
REQ-010 States: IDLE, READ, WRITE; reset state IDLE.
REQ-011 A line_req with line_y < V_PIX SHALL set a 1-deep pending flag and latch line_y.
REQ-012 A line_req arriving while a request is already pending SHALL be dropped and SHALL set err.
REQ-013 A line_req with line_y >= V_PIX SHALL be ignored and SHALL set err.
REQ-014 IDLE->READ when pending is set; the pending read SHALL win over a simultaneous wr_req.
REQ-015 IDLE->WRITE when wr_req=1 and no read is pending.
REQ-016 READ SHALL issue H_PIX reads, one per issue cycle, at addresses line_y*H_PIX+0 to line_y*H_PIX+H_PIX-1, in increasing order.
REQ-017 READ SHALL clear the pending flag on entry, so that a new line_req can be queued during the burst.
REQ-018 READ SHALL exit to IDLE in the cycle after the last read issue.
REQ-019 rd_valid SHALL assert exactly 1 cycle after each read issue, with rd_data=mem_rdata and rd_idx equal to the issued x.
REQ-020 WRITE SHALL last 1 cycle: mem_en=1, mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data, wr_ack=1; next state IDLE.
REQ-021 A wr_addr >= H_PIX*V_PIX SHALL be acked with mem_en=0 and SHALL set err.
REQ-022 line_busy SHALL equal pending OR (state==READ).
REQ-023 mem_en SHALL be 0 in every cycle that is neither a read issue nor a write; mem_we=0 on reads.
REQ-024 Address arithmetic SHALL be 19-bit unsigned with no wrap, since H_PIX*V_PIX <= 2^19.
REQ-025 err is cleared only by reset.

Reset
REQ-026 Assertion of rst (low) SHALL asynchronously force: state IDLE, pending=0, all outputs 0, read counter 0.
REQ-027 Reset during a burst SHALL abort it; no rd_valid SHALL follow for reads issued before reset.
REQ-028 After rst deasserts, the block SHALL accept line_req or wr_req in the first clock.

Configuration
REQ-030 Macro FB_WR_INTERLEAVE_EN selects the write-interleave feature.
REQ-031 With FB_WR_INTERLEAVE_EN defined, a pending wr_req SHALL take one cycle during READ after every WR_GAP consecutive read issues:
- the read stalls for that cycle (no issue, x held);
- the next rd_valid is delayed by 1 cycle;
- the burst then resumes.
REQ-032 Without FB_WR_INTERLEAVE_EN, writes SHALL occur only from IDLE and a burst SHALL always take exactly H_PIX consecutive cycles.

Structure
REQ-040 Package vga_pkg SHALL hold:
- the state enum;
- default H_PIX, V_PIX, FB_DEPTH=H_PIX*V_PIX;
- the pixel width of 24.
REQ-041 Sub-module vga_fb_addr_gen (line base multiply plus x counter) is permitted; the rest stays flat.

Verification
REQ-050 Read line: line_req, line_y=2 -> mem_addr 1280..1919 on consecutive cycles; 640 rd_valid pulses, rd_idx 0..639; line_busy low after the last issue.
REQ-051 Write collision: wr_req and line_req in the same cycle (line_y=0) -> full read burst first; wr_ack follows in the cycle after READ exits.
REQ-052 Errors:
- line_y=480 -> no mem_en, err=1;
- wr_addr=307200 -> wr_ack with mem_en=0, err=1.
REQ-053 Queueing:
- second line_req mid-burst -> queued; the second burst starts immediately after the first;
- a third request while one is pending -> err=1.
REQ-054 Interleave (macro defined, WR_GAP=8): wr_req held during a burst -> write at the 9th burst cycle, mem_we=1; burst length 641 cycles.
REQ-055 Reset at burst cycle 100 -> all outputs 0 in the same cycle; no further rd_valid; a fresh line_req after release starts at x=0.
